// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one byte-wide SPI engine between N_REQ requesters.
// Each grant runs exactly one byte frame: the rd or wr strobe is held for
// XFER_CYCLES, read data is captured at frame end, and the granted requester
// gets a one-cycle done pulse. An idle gap of GAP_CYCLES separates frames.
// Optional build macro SPI_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins) instead of the default round-robin arbitration.
module spi_xfer_arbiter #(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 8,
  parameter int XFER_CYCLES = 9,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    spi_wr,
  output logic                    spi_rd,
  output logic [DATA_W-1:0]       spi_wdata,
  input  logic [DATA_W-1:0]       spi_rdata
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  typedef enum logic [1:0] {IDLE, XFER, CAPT, GAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   gnt_nxt, done_nxt;
  logic [DATA_W-1:0]  rdata_nxt, wdata_nxt;
  logic               wr_nxt, rd_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic               frame_wr, frame_wr_nxt;
  logic               found;
  logic [IDX_W-1:0]   win, cand;
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
`endif

  // Winner search: first requester found scanning from the priority start point
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
`endif
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Frame sequencer: next-state and next-output values, defaults hold everything
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gnt_nxt      = gnt;
    done_nxt     = '0;
    rdata_nxt    = rdata;
    wr_nxt       = spi_wr;
    rd_nxt       = spi_rd;
    wdata_nxt    = spi_wdata;
    owner_nxt    = owner;
    frame_wr_nxt = frame_wr;
`ifndef SPI_ARB_FIXED_PRIO_EN
    rr_nxt       = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt    = win;
          frame_wr_nxt = req_wr[win];
          wdata_nxt    = req_wdata[win*DATA_W +: DATA_W];
          gnt_nxt      = N_REQ'(1) << win;
          wr_nxt       = req_wr[win];
          rd_nxt       = ~req_wr[win];
          cnt_nxt      = CNT_W'(1);
          state_nxt    = XFER;
`ifndef SPI_ARB_FIXED_PRIO_EN
          rr_nxt       = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
`endif
        end
      end
      XFER: begin
        if (cnt == CNT_W'(XFER_CYCLES)) begin
          wr_nxt    = 1'b0;
          rd_nxt    = 1'b0;
          state_nxt = CAPT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CAPT: begin
        done_nxt = N_REQ'(1) << owner;
        if (!frame_wr) rdata_nxt = spi_rdata;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        // cnt never exceeds GAP_CYCLES-1 here, so the increment cannot wrap
        if ((cnt + 1'b1) == CNT_W'(GAP_CYCLES)) state_nxt = IDLE;
        cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      spi_wr    <= 1'b0;
      spi_rd    <= 1'b0;
      spi_wdata <= '0;
      owner     <= '0;
      frame_wr  <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      rdata     <= rdata_nxt;
      spi_wr    <= wr_nxt;
      spi_rd    <= rd_nxt;
      spi_wdata <= wdata_nxt;
      owner     <= owner_nxt;
      frame_wr  <= frame_wr_nxt;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_ptr    <= rr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed bench for spi_xfer_arbiter with a frame-timeline
// reference model checked every cycle, plus literal expectations per scenario.
module tb_spi_xfer_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int X  = 9;
  localparam int G  = 2;
  localparam int PERIOD = 1 + X + 1 + G;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_wr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata, spi_wdata, spi_rdata;
  logic            spi_wr, spi_rd;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  spi_xfer_arbiter #(.N_REQ(N), .DATA_W(DW), .XFER_CYCLES(X), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position m_t within the current frame timeline
  // (0 = idle; 1..X strobe; X+1 capture; X+2 done; idle again at X+2+G).
  int            m_t = 0;
  int            m_owner = 0;
  int            m_ptr = 0;
  bit            m_wr = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk) begin
    int  w, idx;
    bit  fnd;
    if (!rst_n) begin
      m_t = 0; m_owner = 0; m_ptr = 0; m_wr = 1'b0; m_wdata = '0; m_rdata = '0;
    end else begin
      if (m_t == X + 1 && !m_wr) m_rdata = spi_rdata;
      if (m_t == 0 || m_t >= X + 2 + G) begin
        fnd = 1'b0; w = 0;
        for (int k = 0; k < N; k++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_ptr + k) % N;
`endif
          if (!fnd && req[idx]) begin fnd = 1'b1; w = idx; end
        end
        if (fnd) begin
          m_owner = w; m_wr = req_wr[w]; m_wdata = req_wdata[w*DW +: DW];
          m_ptr = (w + 1) % N; m_t = 1;
        end else begin
          m_t = 0;
        end
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_done;
    bit e_strobe;
    if (chk_en) begin
      e_strobe = (m_t >= 1 && m_t <= X);
      e_gnt  = (m_t >= 1 && m_t <= X + 1) ? N'(1) << m_owner : '0;
      e_done = (m_t == X + 2) ? N'(1) << m_owner : '0;
      check("cyc_gnt", 32'(gnt), 32'(e_gnt));
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_spi_wr", 32'(spi_wr), 32'(e_strobe && m_wr));
      check("cyc_spi_rd", 32'(spi_rd), 32'(e_strobe && !m_wr));
      check("cyc_spi_wdata", 32'(spi_wdata), 32'(m_wdata));
      check("cyc_rdata", 32'(rdata), 32'(m_rdata));
      check("cyc_rd_wr_excl", 32'(spi_rd && spi_wr), 32'd0);
    end
  end

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic run_frame(input int idx, input int drop_at, input logic [DW-1:0] wexp,
                           output int nwr, output int nrd, output int ndone, output int nbad,
                           output logic [DW-1:0] rd_at_done);
    bit seen;
    nwr = 0; nrd = 0; ndone = 0; nbad = 0; seen = 1'b0; rd_at_done = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (spi_wr) begin nwr++; if (spi_wdata !== wexp) nbad++; end
      if (spi_rd) nrd++;
      if (drop_at > 0 && (nwr + nrd) == drop_at) req[idx] = 1'b0;
      if (done[idx]) begin ndone++; seen = 1'b1; rd_at_done = rdata; req[idx] = 1'b0; end
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (done[idx]) ndone++;
    end
  endtask

  initial begin
    int nwr, nrd, ndone, nbad, ng;
    logic [DW-1:0] rdv;
    int gcyc[4];
    logic [N-1:0] gval[4];
    logic [N-1:0] prev;

    rst_n = 1'b0; req = '0; req_wr = '0; req_wdata = '0; spi_rdata = '0;

    // 1: reset with both requests asserted
    req = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_spi_wr", 32'(spi_wr), 32'd0);
    check("rst_spi_rd", 32'(spi_rd), 32'd0);
    check("rst_spi_wdata", 32'(spi_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (16) @(negedge clk);

    // 2: single write from requester 0
    req_wr = 2'b01; req_wdata = 16'h00A5; req = 2'b01;
    run_frame(0, 0, 8'hA5, nwr, nrd, ndone, nbad, rdv);
    check("wr_strobe_cycles", 32'(nwr), 32'd9);
    check("wr_rd_cycles", 32'(nrd), 32'd0);
    check("wr_done_pulses", 32'(ndone), 32'd1);
    check("wr_wdata_stable", 32'(nbad), 32'd0);

    // 3: single read from requester 1, then a write that must keep rdata
    spi_rdata = 8'h3C; req_wr = 2'b00; req = 2'b10;
    run_frame(1, 0, 8'h00, nwr, nrd, ndone, nbad, rdv);
    check("rd_strobe_cycles", 32'(nrd), 32'd9);
    check("rd_wr_cycles", 32'(nwr), 32'd0);
    check("rd_done_pulses", 32'(ndone), 32'd1);
    check("rd_rdata_at_done", 32'(rdv), 32'h3C);
    spi_rdata = 8'h55; req_wr = 2'b10; req_wdata = 16'h5A00; req = 2'b10;
    run_frame(1, 0, 8'h5A, nwr, nrd, ndone, nbad, rdv);
    check("wr1_strobe_cycles", 32'(nwr), 32'd9);
    check("wr1_keeps_rdata", 32'(rdata), 32'h3C);

    // 4: contention with both requests held
    req_wr = 2'b11; req_wdata = 16'h2211; req = 2'b11;
    ng = 0; prev = '0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin gval[ng] = gnt; gcyc[ng] = c; ng++; end
      prev = gnt;
    end
    req = '0;
    check("cont_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      check("cont_grant_val", 32'(gval[i]), 32'h1);
`else
      check("cont_grant_val", 32'(gval[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
`endif
      if (i > 0) check("cont_period", 32'(gcyc[i] - gcyc[i-1]), 32'(PERIOD));
    end
    check("cont_period_literal", 32'(PERIOD), 32'd13);
    repeat (16) @(negedge clk);

    // 5: request dropped at strobe cycle 4
    req_wr = 2'b01; req_wdata = 16'h00C3; req = 2'b01;
    run_frame(0, 4, 8'hC3, nwr, nrd, ndone, nbad, rdv);
    check("drop_strobe_cycles", 32'(nwr), 32'd9);
    check("drop_done_pulses", 32'(ndone), 32'd1);

    // 6: reset at strobe cycle 5 of a read frame
    req_wr = 2'b00; spi_rdata = 8'h77; req = 2'b01;
    nrd = 0;
    for (int c = 0; c < 20 && nrd < 5; c++) begin
      @(negedge clk);
      if (spi_rd) nrd++;
    end
    check("abort_reached_cycle5", 32'(nrd), 32'd5);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    check("abort_spi_rd", 32'(spi_rd), 32'd0);
    check("abort_spi_wr", 32'(spi_wr), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done != '0) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_rdata_cleared", 32'(rdata), 32'd0);
    req = 2'b11; rst_n = 1'b1;
    @(negedge clk);
    check("abort_rr_ptr_reset", 32'(gnt), 32'h1);
    req = '0;
    repeat (16) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
